seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 131 +++++++++++++
 tb/tb_seq_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, plus a W-cycle shift-add multiply.
// State | meaning:  IDLE | ready, one-cycle ops complete here;  MUL | shift-add multiply running
module seq_alu #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [3:0]     Sel,
    output logic [2*W-1:0] C,
    output logic           done,
    output logic           busy,
    output logic           Z,
    output logic           err
);
    localparam int SW = $clog2(W);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1111;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_GT  = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b0101;

    logic [0:0]     r_state;
    logic [2*W-1:0] r_c;
    logic           r_done;
    logic           r_z;
    logic           r_err;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [SW-1:0]  r_cnt;

    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;
    logic [SW-1:0]  w_shamt;
    logic [2*W-1:0] w_result;
    logic           w_illegal;
    logic [2*W-1:0] w_acc_next;

    assign w_a_ext = {{W{1'b0}}, A};
    assign w_b_ext = {{W{1'b0}}, B};
    assign w_shamt = B[SW-1:0];

    // Subtracting zero-extended operands in 2W bits yields the sign-extended difference.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (Sel)
            OP_ADD:  w_result = w_a_ext + w_b_ext;
            OP_SUB:  w_result = w_a_ext - w_b_ext;
            OP_AND:  w_result = w_a_ext & w_b_ext;
            OP_OR:   w_result = w_a_ext | w_b_ext;
            OP_XOR:  w_result = w_a_ext ^ w_b_ext;
            OP_EQ:   w_result = (A == B) ? '1 : '0;
            OP_GT:   w_result = (A > B) ? '1 : '0;
            OP_SHL:  w_result = w_a_ext << w_shamt;
            OP_SHR:  w_result = w_a_ext >> w_shamt;
            OP_MUL:  w_result = '0;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_c      <= '0;
            r_done   <= 1'b0;
            r_z      <= 1'b1;
            r_err    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_a_ext;
                        r_mplier <= B;
                        if (Sel == OP_MUL) begin
                            r_state <= S_MUL;
                            r_acc   <= '0;
                            r_cnt   <= SW'(W - 1);
                        end else begin
                            r_c    <= w_result;
                            r_z    <= (w_result == '0);
                            r_err  <= w_illegal;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    // C is only written on the final iteration, so partial products stay hidden.
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_c     <= w_acc_next;
                        r_z     <= (w_acc_next == '0);
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - SW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign C    = r_c;
    assign done = r_done;
    assign busy = (r_state == S_MUL);
    assign Z    = r_z;
    assign err  = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (W=8); observed word is {done,busy,Z,err,C[15:0]}.
module tb_seq_alu;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  Sel;
    logic [15:0] C;
    logic        done;
    logic        busy;
    logic        Z;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Sel(Sel),
        .C(C), .done(done), .busy(busy), .Z(Z), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] obs();
        return {done, busy, Z, err, C};
    endfunction

    // Drives a request, waits one edge, samples 1ns later; start is left high.
    task automatic req(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; Sel = s; A = a; B = b;
        @(posedge clk); #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Sel = '0;
        step(); step();
        n_vec++;
        if (obs() !== 20'h20000) begin n_err++; $display("FAIL reset: got %h exp %h", obs(), 20'h20000); end
        rst_n = 1'b1;
        step();
        n_vec++;
        if (obs() !== 20'h20000) begin n_err++; $display("FAIL reset_idle: got %h exp %h", obs(), 20'h20000); end
    endtask

    task automatic test_sum_sub();
        req(4'b0000, 8'hFF, 8'h01);
        n_vec++;
        if (obs() !== 20'h80100) begin n_err++; $display("FAIL sum_ff_01: got %h exp %h", obs(), 20'h80100); end
        start = 1'b0; A = 8'h55; B = 8'h66;
        step();
        n_vec++;
        if (obs() !== 20'h00100) begin n_err++; $display("FAIL sum_hold: got %h exp %h", obs(), 20'h00100); end
        req(4'b1111, 8'h03, 8'h05); start = 1'b0;
        n_vec++;
        if (obs() !== 20'h8FFFE) begin n_err++; $display("FAIL sub_neg: got %h exp %h", obs(), 20'h8FFFE); end
        req(4'b1111, 8'h05, 8'h05); start = 1'b0;
        n_vec++;
        if (obs() !== 20'hA0000) begin n_err++; $display("FAIL sub_zero: got %h exp %h", obs(), 20'hA0000); end
    endtask

    task automatic test_logic_cmp();
        logic [3:0]  sels [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b0011, 4'b0011, 4'b1000, 4'b1000};
        logic [7:0]  as   [8] = '{8'hF0, 8'hF0, 8'hF0, 8'h05, 8'h03, 8'h07, 8'h3C, 8'h3C};
        logic [7:0]  bs   [8] = '{8'h3C, 8'h3C, 8'h3C, 8'h03, 8'h05, 8'h07, 8'h3C, 8'h3D};
        logic [19:0] exps [8] = '{20'h80030, 20'h800FC, 20'h800CC, 20'h8FFFF,
                                  20'hA0000, 20'hA0000, 20'h8FFFF, 20'hA0000};
        for (int i = 0; i < 8; i++) begin
            req(sels[i], as[i], bs[i]); start = 1'b0;
            n_vec++;
            if (obs() !== exps[i]) begin
                n_err++; $display("FAIL logic_cmp[%0d]: got %h exp %h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  sels [5] = '{4'b0110, 4'b1100, 4'b0110, 4'b1100, 4'b0110};
        logic [7:0]  as   [5] = '{8'h81, 8'h80, 8'h5A, 8'hA5, 8'hFF};
        logic [7:0]  bs   [5] = '{8'h0F, 8'h07, 8'h08, 8'h10, 8'h03};
        logic [19:0] exps [5] = '{20'h84080, 20'h80001, 20'h8005A, 20'h800A5, 20'h807F8};
        for (int i = 0; i < 5; i++) begin
            req(sels[i], as[i], bs[i]); start = 1'b0;
            n_vec++;
            if (obs() !== exps[i]) begin
                n_err++; $display("FAIL shift[%0d]: got %h exp %h", i, obs(), exps[i]);
            end
        end
    endtask

    task automatic test_illegal();
        req(4'b0111, 8'h12, 8'h34); start = 1'b0;
        n_vec++;
        if (obs() !== 20'hB0000) begin n_err++; $display("FAIL illegal_0111: got %h exp %h", obs(), 20'hB0000); end
        req(4'b1000, 8'h3C, 8'h3C); start = 1'b0;
        n_vec++;
        if (obs() !== 20'h8FFFF) begin n_err++; $display("FAIL eq_after_err: got %h exp %h", obs(), 20'h8FFFF); end
        req(4'b1001, 8'hFF, 8'hFF); start = 1'b0;
        n_vec++;
        if (obs() !== 20'hB0000) begin n_err++; $display("FAIL illegal_1001: got %h exp %h", obs(), 20'hB0000); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sels [4] = '{4'b0000, 4'b0001, 4'b1111, 4'b1010};
        logic [7:0]  as   [4] = '{8'h01, 8'hFF, 8'h00, 8'h77};
        logic [7:0]  bs   [4] = '{8'h02, 8'h0F, 8'h01, 8'h11};
        logic [19:0] exps [4] = '{20'h80003, 20'h8000F, 20'h8FFFF, 20'hB0000};
        for (int i = 0; i < 4; i++) begin
            req(sels[i], as[i], bs[i]);
            n_vec++;
            if (obs() !== exps[i]) begin
                n_err++; $display("FAIL b2b[%0d]: got %h exp %h", i, obs(), exps[i]);
            end
        end
        start = 1'b0;
        step();
        n_vec++;
        if (obs() !== 20'h30000) begin n_err++; $display("FAIL b2b_end: got %h exp %h", obs(), 20'h30000); end
    endtask

    task automatic test_mul();
        int cnt;
        req(4'b0000, 8'h12, 8'h34); start = 1'b0;
        n_vec++;
        if (obs() !== 20'h80046) begin n_err++; $display("FAIL mul_pre: got %h exp %h", obs(), 20'h80046); end
        req(4'b0101, 8'hFF, 8'hFF);
        start = 1'b0; A = 8'h00; B = 8'h00;
        n_vec++;
        if (obs() !== 20'h40046) begin n_err++; $display("FAIL mul_accept: got %h exp %h", obs(), 20'h40046); end
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin start = 1'b1; Sel = 4'b0000; A = 8'h01; B = 8'h01; end
            else start = 1'b0;
            step();
            if (i < 8) begin
                n_vec++;
                if (obs() !== 20'h40046) begin
                    n_err++; $display("FAIL mul_iter[%0d]: got %h exp %h", i, obs(), 20'h40046);
                end
            end else begin
                n_vec++;
                if (obs() !== 20'h8FE01) begin n_err++; $display("FAIL mul_ff_ff: got %h exp %h", obs(), 20'h8FE01); end
            end
        end
        step();
        n_vec++;
        if (obs() !== 20'h0FE01) begin n_err++; $display("FAIL mul_hold: got %h exp %h", obs(), 20'h0FE01); end

        req(4'b0101, 8'h00, 8'h07); start = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done) begin cnt = i; break; end
        end
        n_vec++;
        if (cnt !== 8) begin n_err++; $display("FAIL mul_zero_cycles: got %0d exp %0d", cnt, 8); end
        n_vec++;
        if (obs() !== 20'hA0000) begin n_err++; $display("FAIL mul_zero: got %h exp %h", obs(), 20'hA0000); end
    endtask

    task automatic test_reset_mid_mul();
        req(4'b0000, 8'h12, 8'h34); start = 1'b0;
        req(4'b0101, 8'hFF, 8'hFF); start = 1'b0;
        step(); step(); step();
        n_vec++;
        if (obs() !== 20'h40046) begin n_err++; $display("FAIL abort_pre: got %h exp %h", obs(), 20'h40046); end
        rst_n = 1'b0;
        step();
        n_vec++;
        if (obs() !== 20'h20000) begin n_err++; $display("FAIL abort_reset: got %h exp %h", obs(), 20'h20000); end
        rst_n = 1'b1;
        req(4'b0001, 8'hF0, 8'h3C); start = 1'b0;
        n_vec++;
        if (obs() !== 20'h80030) begin n_err++; $display("FAIL abort_and: got %h exp %h", obs(), 20'h80030); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (obs() !== 20'h00030) begin
                n_err++; $display("FAIL abort_no_done[%0d]: got %h exp %h", i, obs(), 20'h00030);
            end
        end
    endtask

    task automatic test_reset_collide();
        rst_n = 1'b0;
        req(4'b0000, 8'h01, 8'h01);
        n_vec++;
        if (obs() !== 20'h20000) begin n_err++; $display("FAIL collide_reset: got %h exp %h", obs(), 20'h20000); end
        rst_n = 1'b1; start = 1'b0;
        step();
        n_vec++;
        if (obs() !== 20'h20000) begin n_err++; $display("FAIL collide_dropped: got %h exp %h", obs(), 20'h20000); end
    endtask

    initial begin
        test_reset();
        test_sum_sub();
        test_logic_cmp();
        test_shift();
        test_illegal();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        test_reset_collide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule
